// File: rtl/kuuga_mem_arbiter.sv
// kuuga_mem_arbiter: shares one AXI4-Lite master between the Kuuga fetch and LSU ports, one transaction at a time.
// Define KUUGA_ARB_DATA_PRIORITY_EN for fixed data priority; otherwise contention is resolved round-robin.
module kuuga_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic                    instr_err_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  state_t                    r_state, w_next_state;
  logic                      r_owner, r_we, r_aw_done, r_w_done;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_be;
  logic                      r_instr_rvalid, r_instr_err, r_data_rvalid, r_data_err;
  logic [DATA_WIDTH-1:0]     r_instr_rdata, r_data_rdata;
  logic                      w_grant_instr, w_grant_data, w_grant;
  logic                      w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
`ifndef KUUGA_ARB_DATA_PRIORITY_EN
  logic                      r_last_owner;
`endif

  // Arbitration: grants are only issued in IDLE
  always_comb begin
    w_grant_instr = 1'b0;
    w_grant_data  = 1'b0;
    if (r_state == S_IDLE) begin
      if (instr_req_i && data_req_i) begin
`ifdef KUUGA_ARB_DATA_PRIORITY_EN
        w_grant_data = 1'b1;
`else
        if (r_last_owner == OWNER_DATA) begin
          w_grant_instr = 1'b1;
        end else begin
          w_grant_data = 1'b1;
        end
`endif
      end else begin
        w_grant_instr = instr_req_i;
        w_grant_data  = data_req_i;
      end
    end else begin
      w_grant_instr = 1'b0;
      w_grant_data  = 1'b0;
    end
  end

  assign w_grant     = w_grant_instr | w_grant_data;
  assign instr_gnt_o = w_grant_instr;
  assign data_gnt_o  = w_grant_data;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_w_hs  = m_axi_wvalid & m_axi_wready;
  assign w_r_hs  = (r_state == S_RD_DATA) & m_axi_rvalid;
  assign w_b_hs  = (r_state == S_WR_RESP) & m_axi_bvalid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = (w_grant_data && data_we_i) ? S_WR_REQ : S_RD_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD_ADDR: w_next_state = m_axi_arready ? S_RD_DATA : S_RD_ADDR;
      S_RD_DATA: w_next_state = m_axi_rvalid ? S_IDLE : S_RD_DATA;
      S_WR_REQ: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_next_state = S_WR_RESP;
        end else begin
          w_next_state = S_WR_REQ;
        end
      end
      S_WR_RESP: w_next_state = m_axi_bvalid ? S_IDLE : S_WR_RESP;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // AXI channel controls; AW and W each drop on their own handshake
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (r_state)
      S_RD_ADDR: m_axi_arvalid = 1'b1;
      S_RD_DATA: m_axi_rready  = 1'b1;
      S_WR_REQ: begin
        m_axi_awvalid = ~r_aw_done;
        m_axi_wvalid  = ~r_w_done;
      end
      S_WR_RESP: m_axi_bready = 1'b1;
      default: m_axi_arvalid = 1'b0;
    endcase
  end

  assign m_axi_awaddr = r_addr;
  assign m_axi_araddr = r_addr;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = r_wdata;
  assign m_axi_wstrb  = r_be;

  // Request capture on grant and write-handshake tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= OWNER_DATA;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_grant) begin
      r_owner   <= w_grant_data ? OWNER_DATA : OWNER_INSTR;
      r_we      <= w_grant_data & data_we_i;
      r_addr    <= w_grant_data ? data_addr_i : instr_addr_i;
      r_wdata   <= w_grant_data ? data_wdata_i : '0;
      r_be      <= w_grant_data ? data_be_i : '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_aw_done <= r_aw_done | w_aw_hs;
      r_w_done  <= r_w_done | w_w_hs;
    end
  end

`ifndef KUUGA_ARB_DATA_PRIORITY_EN
  // Round-robin history; resets to DATA so the first contention favours INSTR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWNER_DATA;
    end else if (w_grant) begin
      r_last_owner <= w_grant_data ? OWNER_DATA : OWNER_INSTR;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end
`endif

  // Completion: capture response on the R/B handshake, pulse owner's rvalid next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_rvalid <= 1'b0;
      r_instr_err    <= 1'b0;
      r_instr_rdata  <= '0;
      r_data_rvalid  <= 1'b0;
      r_data_err     <= 1'b0;
      r_data_rdata   <= '0;
    end else begin
      r_instr_rvalid <= w_r_hs & (r_owner == OWNER_INSTR);
      r_instr_err    <= w_r_hs & (r_owner == OWNER_INSTR) & (m_axi_rresp != 2'b00);
      r_data_rvalid  <= (w_r_hs | w_b_hs) & (r_owner == OWNER_DATA);
      r_data_err     <= (r_owner == OWNER_DATA) &
                        ((w_r_hs & (m_axi_rresp != 2'b00)) | (w_b_hs & (m_axi_bresp != 2'b00)));
      if (w_r_hs && (r_owner == OWNER_INSTR)) begin
        r_instr_rdata <= m_axi_rdata;
      end else begin
        r_instr_rdata <= r_instr_rdata;
      end
      if (w_r_hs && (r_owner == OWNER_DATA)) begin
        r_data_rdata <= m_axi_rdata;
      end else begin
        r_data_rdata <= r_data_rdata;
      end
    end
  end

  assign instr_rvalid_o = r_instr_rvalid;
  assign instr_err_o    = r_instr_err;
  assign instr_rdata_o  = r_instr_rdata;
  assign data_rvalid_o  = r_data_rvalid;
  assign data_err_o     = r_data_err;
  assign data_rdata_o   = r_data_rdata;
endmodule
